// File: rtl/tetris_input_arbiter.sv
// rtl/tetris_input_arbiter.sv - button sync, debounce, auto-repeat and fixed-priority command arbiter
// Define TETRIS_ROTATE_REPEAT_EN to give rotate the same auto-repeat as left/right/down.
module tetris_input_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 15_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       button_left,
  input  logic       button_right,
  input  logic       button_down,
  input  logic       button_rotate,
  input  logic       sw_pause,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] btn_state
);

  // Button index order matches btn_state: 0 left, 1 right, 2 down, 3 rotate.
`ifdef TETRIS_ROTATE_REPEAT_EN
  localparam int NREP = 4;
`else
  localparam int NREP = 3;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  localparam logic [2:0] CODE_NONE   = 3'd0;
  localparam logic [2:0] CODE_LEFT   = 3'd1;
  localparam logic [2:0] CODE_RIGHT  = 3'd2;
  localparam logic [2:0] CODE_DOWN   = 3'd3;
  localparam logic [2:0] CODE_ROTATE = 3'd4;

  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d, deb_prev_q;
  logic [CNT_W-1:0] deb_cnt_q [4];
  logic [CNT_W-1:0] deb_cnt_d [4];
  logic [1:0]       rep_st_q  [NREP];
  logic [1:0]       rep_st_d  [NREP];
  logic [CNT_W-1:0] rep_cnt_q [NREP];
  logic [CNT_W-1:0] rep_cnt_d [NREP];
  logic [3:0]       press, evt;
  logic [3:0]       pend_q, pend_d, avail, grant;
  logic             valid_q, valid_d, load;
  logic [2:0]       code_q, code_d;

  assign raw       = {button_rotate, button_down, button_right, button_left};
  assign press     = deb_q & ~deb_prev_q;
  assign btn_state = deb_q;
  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = ~deb_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // Buttons without a repeat FSM keep the bare press event.
  always_comb begin
    evt = press;
    for (int i = 0; i < NREP; i++) begin
      rep_st_d[i]  = rep_st_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      evt[i]       = 1'b0;
      if (sw_pause || !deb_q[i]) begin
        rep_st_d[i]  = ST_IDLE;
        rep_cnt_d[i] = '0;
      end else begin
        case (rep_st_q[i])
          ST_IDLE: begin
            if (press[i]) begin
              evt[i]       = 1'b1;
              rep_st_d[i]  = ST_DELAY;
              rep_cnt_d[i] = '0;
            end
          end
          ST_DELAY: begin
            if (rep_cnt_q[i] == DELAY_LAST) begin
              evt[i]       = 1'b1;
              rep_st_d[i]  = ST_REPEAT;
              rep_cnt_d[i] = '0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rep_cnt_q[i] == RATE_LAST) begin
              evt[i]       = 1'b1;
              rep_cnt_d[i] = '0;
            end else begin
              rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
          end
          default: begin
            rep_st_d[i]  = ST_IDLE;
            rep_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // A presented command is only replaced once accepted, so it is never withdrawn.
  always_comb begin
    avail   = sw_pause ? 4'b0000 : pend_q;
    load    = !valid_q || cmd_ready;
    grant   = 4'b0000;
    valid_d = valid_q;
    code_d  = code_q;
    if (load) begin
      valid_d = |avail;
      code_d  = CODE_NONE;
      if (avail[3]) begin
        grant[3] = 1'b1;
        code_d   = CODE_ROTATE;
      end else if (avail[0]) begin
        grant[0] = 1'b1;
        code_d   = CODE_LEFT;
      end else if (avail[1]) begin
        grant[1] = 1'b1;
        code_d   = CODE_RIGHT;
      end else if (avail[2]) begin
        grant[2] = 1'b1;
        code_d   = CODE_DOWN;
      end
    end
    pend_d = sw_pause ? 4'b0000 : ((pend_q & ~grant) | evt);
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      code_q     <= CODE_NONE;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      for (int i = 0; i < NREP; i++) begin
        rep_st_q[i]  <= ST_IDLE;
        rep_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      for (int i = 0; i < NREP; i++) begin
        rep_st_q[i]  <= rep_st_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tetris_input_arbiter.sv
// tb/tb_tetris_input_arbiter.sv - scoreboard bench for tetris_input_arbiter with a timing-rule reference model
module tb_tetris_input_arbiter;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] btns;
  logic       sw_pause;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [3:0] btn_state;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [3:0] m_sy1, m_sy2, m_deb, m_prev, m_nd, m_ev, m_pend;
  int         m_run   [4];
  int         m_armed [4];
  logic       m_slot;
  logic       rst_seen = 1'b0;
  exp_t       sb[$];

  tetris_input_arbiter #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (24)
  ) dut (
    .clk_50       (clk),
    .reset        (reset),
    .button_left  (btns[0]),
    .button_right (btns[1]),
    .button_down  (btns[2]),
    .button_rotate(btns[3]),
    .sw_pause     (sw_pause),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .btn_state    (btn_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, got, exp);
    end
  endtask

  function automatic bit rep_en(input int b);
`ifdef TETRIS_ROTATE_REPEAT_EN
    return 1'b1;
`else
    return b != 3;
`endif
  endfunction

  // Held-time rule: fire at press, at RD cycles after it, then every RR cycles.
  function automatic bit fires(input int held);
    return (held >= RD) && (((held - RD) % RR) == 0);
  endfunction

  function automatic int prio(input int k);
    case (k)
      0:       return 3;
      1:       return 0;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      m_sy1 = '0; m_sy2 = '0; m_deb = '0; m_prev = '0; m_pend = '0; m_slot = 1'b0;
      for (int b = 0; b < 4; b++) begin
        m_run[b]   = 0;
        m_armed[b] = -1;
      end
      sb.delete();
      rst_seen = 1'b1;
    end else begin
      m_nd = m_deb;
      for (int b = 0; b < 4; b++) begin
        if (m_sy2[b] != m_deb[b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == DEB) begin
          m_nd[b]  = ~m_deb[b];
          m_run[b] = 0;
        end
      end
      for (int b = 0; b < 4; b++) begin
        m_ev[b] = 1'b0;
        if (sw_pause) m_armed[b] = -1;
        else if (m_deb[b] && !m_prev[b]) begin
          m_armed[b] = cyc;
          m_ev[b]    = 1'b1;
        end else if (!m_deb[b]) m_armed[b] = -1;
        else if (m_armed[b] >= 0 && rep_en(b)) m_ev[b] = fires(cyc - m_armed[b]);
      end
      if (!m_slot || cmd_ready) begin
        m_slot = 1'b0;
        if (!sw_pause) begin
          for (int k = 0; k < 4; k++) begin
            if (!m_slot && m_pend[prio(k)]) begin
              m_slot = 1'b1;
              m_pend[prio(k)] = 1'b0;
              sb.push_back('{cyc + 1, 3'(prio(k) + 1)});
            end
          end
        end
      end
      m_pend = sw_pause ? 4'b0000 : (m_pend | m_ev);
      m_prev = m_deb;
      m_deb  = m_nd;
      m_sy2  = m_sy1;
      m_sy1  = btns;
    end
    cyc++;
  endtask

  task automatic monitor_step();
    if (rst_seen) begin
      rst_seen = 1'b0;
      check("reset_state", 32'({cmd_valid, cmd_code, btn_state}), 32'd0);
    end else begin
      check("btn_state", 32'(btn_state), 32'(m_deb));
      if (sb.size() > 0) begin
        check("cmd", 32'({cmd_valid, cmd_code}), 32'({1'b1, sb[0].code}));
        if (cmd_ready) void'(sb.pop_front());
      end else begin
        check("idle_out", 32'({cmd_valid, cmd_code}), 32'd0);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; btns = 4'b0000; sw_pause = 1'b0; cmd_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(50);

    // left glitch then a short hold
    btns = 4'b0001; tick(2);
    btns = 4'b0000; tick(10);
    btns = 4'b0001; tick(10);
    btns = 4'b0000; tick(20);

    // down held long enough for several repeats
    btns = 4'b0100; tick(60);
    btns = 4'b0000; tick(20);

    // three presses together under a stalled consumer
    cmd_ready = 1'b0; btns = 4'b1101; tick(14);
    btns = 4'b0000; tick(4);
    cmd_ready = 1'b1; tick(15);

    // pause while right held, unpause while held, then re-press
    btns = 4'b0010; tick(15);
    sw_pause = 1'b1; tick(30);
    sw_pause = 1'b0; tick(30);
    btns = 4'b0000; tick(10);
    btns = 4'b0010; tick(15);
    btns = 4'b0000; tick(15);

    // left and right together
    btns = 4'b0011; tick(12);
    btns = 4'b0000; tick(15);

    // reset while a command is stalled
    cmd_ready = 1'b0; btns = 4'b1000; tick(12);
    reset = 1'b1; btns = 4'b0000; tick(1);
    reset = 1'b0; cmd_ready = 1'b1; tick(15);

    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 29) == 0) btns[b] = ~btns[b];
      cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) sw_pause = ~sw_pause;
      tick(1);
    end

    btns = 4'b0000; sw_pause = 1'b0; cmd_ready = 1'b1;
    tick(100);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
